lcd_ctrl: RTL

- Drives the HD44780-compatible character LCD in 4-bit write-only mode on the Tang Nano 9K board.
- Sits downstream of the CPU I/O register decode.
- Top level turns a CPU store to the LCD data/command address into a one-cycle wr_valid with the byte and RS flag; this block runs the power-on init, nibble splitting, E pulse timing and post-command execution delays, so the CPU no longer bit-bangs lcd_e/lcd_rs/lcd_db.
- Software polls busy (readable via I/O decode) before writing.

---
 rtl/lcd_ctrl_if.sv | 12 +
 rtl/lcd_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/lcd_ctrl_if.sv
// Byte-write handshake between the CPU I/O decode and the LCD controller.
// The master drives a one-cycle request; the slave reports when it can take one.
interface lcd_ctrl_if;
    logic       wr_valid;
    logic       wr_rs;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       busy;

    modport master (output wr_valid, wr_rs, wr_data, input  wr_ready, busy);
    modport slave  (input  wr_valid, wr_rs, wr_data, output wr_ready, busy);
endinterface

// File: rtl/lcd_ctrl.sv
// HD44780 4-bit write-only controller: power-on init, nibble split, E pulse
// timing and per-command execution waits behind a simple ready/valid port.
module lcd_ctrl #(
    parameter logic [19:0] T_POWERON = 20'd405000,
    parameter logic [7:0]  T_SETUP   = 8'd2,
    parameter logic [7:0]  T_PULSE   = 8'd12,
    parameter logic [7:0]  T_HOLD    = 8'd2,
    parameter logic [15:0] T_CMD     = 16'd1080,
    parameter logic [15:0] T_CLR     = 16'd44280
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    lcd_ctrl_if.slave   bus,
    output logic        lcd_e,
    output logic        lcd_rw,
    output logic        lcd_rs,
    output logic [3:0]  lcd_db
);

    typedef enum logic [2:0] {
        S_PWR_WAIT, S_LOAD, S_SETUP, S_PULSE, S_HOLD, S_EXEC, S_IDLE
    } state_t;

    state_t      r_state, w_next;
    // 20 bits so the 405000-cycle power-on wait fits in the shared counter
    logic [19:0] r_cnt, w_cnt;
    logic [2:0]  r_idx;
    logic        r_init, r_low, r_e, r_lcd_rs;
    logic [3:0]  r_lcd_db;
    logic [7:0]  r_byte;
    logic        r_rs_b, r_nib_only, r_long;
    logic [9:0]  w_rom;
    logic        w_done, w_accept, w_ld_rom, w_ld_db, w_low, w_idx_inc, w_init_end;
    logic [3:0]  w_db;
    logic        w_rs;

    // {nibble_only, long_wait, byte}; nibble-only entries send byte[7:4]
    function automatic logic [9:0] init_rom(input logic [2:0] idx);
        case (idx)
            3'd0:    init_rom = {1'b1, 1'b1, 8'h30};
            3'd1:    init_rom = {1'b1, 1'b1, 8'h30};
            3'd2:    init_rom = {1'b1, 1'b0, 8'h30};
            3'd3:    init_rom = {1'b1, 1'b0, 8'h20};
            3'd4:    init_rom = {1'b0, 1'b0, 8'h28};
            3'd5:    init_rom = {1'b0, 1'b0, 8'h0C};
            3'd6:    init_rom = {1'b0, 1'b1, 8'h01};
            default: init_rom = {1'b0, 1'b0, 8'h06};
        endcase
    endfunction

    assign w_rom  = init_rom(r_idx);
    assign w_done = (r_cnt == 20'd0);

    always_comb begin
        w_next     = r_state;
        w_cnt      = r_cnt - 20'd1;
        w_accept   = 1'b0;
        w_ld_rom   = 1'b0;
        w_ld_db    = 1'b0;
        w_db       = r_byte[7:4];
        w_rs       = r_rs_b;
        w_low      = r_low;
        w_idx_inc  = 1'b0;
        w_init_end = 1'b0;
        case (r_state)
            S_PWR_WAIT: if (w_done) w_next = S_LOAD;
            S_LOAD: begin
                w_next  = S_SETUP;
                w_cnt   = {12'd0, T_SETUP};
                w_ld_db = 1'b1;
                w_low   = 1'b0;
                if (r_init) begin
                    w_ld_rom = 1'b1;
                    w_db     = w_rom[7:4];
                    w_rs     = 1'b0;
                end
            end
            S_SETUP: if (w_done) begin
                w_next = S_PULSE;
                w_cnt  = {12'd0, T_PULSE};
            end
            S_PULSE: if (w_done) begin
                w_next = S_HOLD;
                w_cnt  = {12'd0, T_HOLD};
            end
            S_HOLD: if (w_done) begin
                if (!r_low && !r_nib_only) begin
                    // low nibble follows directly, no gap cycle
                    w_next  = S_SETUP;
                    w_cnt   = {12'd0, T_SETUP};
                    w_ld_db = 1'b1;
                    w_db    = r_byte[3:0];
                    w_low   = 1'b1;
                end else begin
                    w_next = S_EXEC;
                    w_cnt  = r_long ? {4'd0, T_CLR} : {4'd0, T_CMD};
                end
            end
            S_EXEC: if (w_done) begin
                if (r_init && r_idx != 3'd7) begin
                    w_next    = S_LOAD;
                    w_idx_inc = 1'b1;
                end else begin
                    w_next     = S_IDLE;
                    w_init_end = 1'b1;
                end
            end
            S_IDLE: begin
                w_cnt = r_cnt;
                if (bus.wr_valid) begin
                    w_next   = S_LOAD;
                    w_accept = 1'b1;
                end
            end
            default: begin
                w_next = S_PWR_WAIT;
                w_cnt  = T_POWERON;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            r_state  <= S_PWR_WAIT;
            r_cnt    <= T_POWERON;
            r_e      <= 1'b0;
            r_lcd_db <= 4'd0;
            r_lcd_rs <= 1'b0;
            r_init   <= 1'b1;
            r_idx    <= 3'd0;
            r_low    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt;
            r_e     <= (w_next == S_PULSE);
            r_low   <= w_low;
            if (w_ld_db) begin
                r_lcd_db <= w_db;
                r_lcd_rs <= w_rs;
            end
            if (w_next == S_PWR_WAIT) begin
                r_init <= 1'b1;
                r_idx  <= 3'd0;
            end else begin
                if (w_idx_inc)  r_idx  <= r_idx + 3'd1;
                if (w_init_end) r_init <= 1'b0;
            end
        end
    end

    // Byte under transfer: from the CPU on accept, from the ROM during init
    always_ff @(posedge sys_clk) begin
        if (w_accept) begin
            r_byte     <= bus.wr_data;
            r_rs_b     <= bus.wr_rs;
            r_nib_only <= 1'b0;
            r_long     <= !bus.wr_rs && (bus.wr_data[7:2] == 6'd0) && (bus.wr_data[1:0] != 2'd0);
        end else if (w_ld_rom) begin
            r_byte     <= w_rom[7:0];
            r_rs_b     <= 1'b0;
            r_nib_only <= w_rom[9];
            r_long     <= w_rom[8];
        end
    end

    assign bus.wr_ready = (r_state == S_IDLE);
    assign bus.busy     = (r_state != S_IDLE);
    assign lcd_e        = r_e;
    assign lcd_rw       = 1'b0;
    assign lcd_rs       = r_lcd_rs;
    assign lcd_db       = r_lcd_db;

endmodule
